// File: rtl/fp16_pkg.sv
// Shared constants, FSM state type and helpers for the binary16 multiplier front end.
package fp16_pkg;

   localparam int BIAS = 15;
   localparam int MW   = 10;
   localparam int EW   = 5;
   localparam int SIGW = 2 * (MW + 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } mul_state_t;

   // A binary16 value is zero when its exponent and mantissa fields are both clear.
   function automatic logic is_zero16(input logic [15:0] x);
      return (x[14:0] == 15'd0);
   endfunction

endpackage

// File: rtl/fp16_unpack.sv
// Splits a binary16 value into sign, exponent field and significand with hidden bit.
// Subnormals keep a hidden bit of 0 and are not pre-normalised.
module fp16_unpack
   import fp16_pkg::*;
(
   input  logic [15:0]   x,
   output logic          sign,
   output logic [EW-1:0] exp,
   output logic [MW:0]   sig,
   output logic          is_zero,
   output logic          is_infnan
);

   assign sign      = x[15];
   assign exp       = x[14:10];
   assign sig       = {(x[14:10] != 5'd0), x[MW-1:0]};
   assign is_zero   = is_zero16(x);
   assign is_infnan = &x[14:10];

endmodule

// File: rtl/fp16_sig_mul.sv
// Sequential binary16 multiplier front end: 11-step shift-add significand product
// plus biased exponent sum, handed downstream as a raw {sig, exp, sign} triple.
module fp16_sig_mul #(
   parameter int BIAS = 15,
   parameter int MW   = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       a,
   input  logic [15:0]       b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*MW+1:0]   sig,
   output logic [4:0]        exp,
   output logic              sign,
   output logic              exp_ovf,
   output logic              exp_unf,
   output logic              zero
);

   import fp16_pkg::*;

   localparam int SW = MW + 1;
   localparam int PW = 2 * SW;
   localparam logic [3:0]        LAST_CNT = 4'(SW - 1);
   localparam logic signed [6:0] BIAS_7   = 7'(BIAS);

   mul_state_t state_q, state_d;

   logic [PW-1:0] acc_q, mcand_q, acc_step;
   logic [SW-1:0] mplier_q;
   logic [3:0]    cnt_q;
   logic          last_step;

   // Exponent/flag results are computed at capture and parked until the product is done.
   logic [4:0] exp_p;
   logic       sign_p, ovf_p, unf_p, zero_p;

   logic          sign_a, sign_b, zero_a, zero_b, inf_a, inf_b;
   logic [4:0]    exp_a, exp_b;
   logic [MW:0]   sig_a, sig_b;

   logic signed [6:0] e_sum;
   logic              cap_zero, cap_ovf, cap_unf;
   logic [4:0]        cap_exp;

   fp16_unpack u_unpack_a (
      .x         (a),
      .sign      (sign_a),
      .exp       (exp_a),
      .sig       (sig_a),
      .is_zero   (zero_a),
      .is_infnan (inf_a)
   );

   fp16_unpack u_unpack_b (
      .x         (b),
      .sign      (sign_b),
      .exp       (exp_b),
      .sig       (sig_b),
      .is_zero   (zero_b),
      .is_infnan (inf_b)
   );

   // Sum of biased exponents as a 7-bit signed value; range is -15..47 so it never wraps.
   assign e_sum    = signed'({2'b00, exp_a}) + signed'({2'b00, exp_b}) - BIAS_7;
   assign cap_zero = zero_a | zero_b;
   assign cap_ovf  = !cap_zero && ((e_sum >= 7'sd31) || inf_a || inf_b);
   assign cap_unf  = !cap_zero && (e_sum <= 7'sd0);
   assign cap_exp  = (cap_zero || cap_unf) ? 5'd0 :
                     cap_ovf               ? 5'h1f : e_sum[4:0];

   assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign last_step = (state_q == MUL) && (cnt_q == LAST_CNT);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and handshake outputs.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned
      // and infers a latch.
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = MUL;
         end
         MUL: begin
            if (cnt_q == LAST_CNT) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture and one shift-add step per MUL cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         exp_p    <= '0;
         sign_p   <= 1'b0;
         ovf_p    <= 1'b0;
         unf_p    <= 1'b0;
         zero_p   <= 1'b0;
      end else if (state_q == IDLE && in_valid) begin
         acc_q    <= '0;
         mcand_q  <= PW'(sig_a);
         mplier_q <= sig_b;
         cnt_q    <= '0;
         exp_p    <= cap_exp;
         sign_p   <= sign_a ^ sign_b;
         ovf_p    <= cap_ovf;
         unf_p    <= cap_unf;
         zero_p   <= cap_zero;
      end else if (state_q == MUL) begin
         acc_q    <= acc_step;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 4'd1;
      end
   end

   // Result registers, loaded only on the final MUL step so they hold through DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig     <= '0;
         exp     <= '0;
         sign    <= 1'b0;
         exp_ovf <= 1'b0;
         exp_unf <= 1'b0;
         zero    <= 1'b0;
      end else if (last_step) begin
         sig     <= zero_p ? '0 : acc_step;
         exp     <= exp_p;
         sign    <= sign_p;
         exp_ovf <= ovf_p;
         exp_unf <= unf_p;
         zero    <= zero_p;
      end
   end

endmodule

// File: doc/fp16_sig_mul.md
# fp16_sig_mul

Sequential half-precision multiplier front end. It accepts two IEEE-754 binary16 operands, forms the 22-bit significand product with an 11-cycle shift-add loop, and adds the biased exponents. It presents the raw `{sig, exp, sign}` triple to the downstream normalise/round stage (`sig[21:0]`, `exp[4:0]`, `sign`), which produces the final 16-bit result and its under/over flags.

## Interface
Parameters:
- `BIAS`, 15: exponent bias subtracted from the exponent sum.
- `MW`, 10: stored mantissa width; the significand is MW+1 bits and the product is 2·(MW+1) = 22 bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operands `a`/`b` are valid.
- `in_ready` out 1: block can accept operands.
- `a` in 16: binary16 operand A.
- `b` in 16: binary16 operand B.
- `out_valid` out 1: result triple is valid.
- `out_ready` in 1: downstream consumes the result.
- `sig` out 22: unnormalised significand product. The leading 1 is at bit 21 or bit 20.
- `exp` out 5: biased exponent before normalisation, saturated.
- `sign` out 1: `a[15] ^ b[15]`.
- `exp_ovf` out 1: exponent sum ≥ 31, or either operand has exponent field 31.
- `exp_unf` out 1: exponent sum ≤ 0 and result is not zero.
- `zero` out 1: either operand is ±0.

## Operation
- States: IDLE, MUL, DONE.
- IDLE: `in_ready`=1. When `in_valid` is high, operands are captured and the state moves to MUL.
- Capture rules:
  - Hidden bit is `(exp_field != 0)`.
  - `mcand` = `{hid_a, a[9:0]}`, zero-extended to 22 bits.
  - `mplier` = `{hid_b, b[9:0]}`.
  - `acc` = 0, `cnt` = 0.
- MUL, one step per cycle: if `mplier[0]`, then `acc += mcand`. Then `mcand <<= 1`, `mplier >>= 1`, `cnt++`. After the step with `cnt`=10 (11 steps total), the state moves to DONE.
- Exponent arithmetic, done once at capture:
  - `e` = `ea + eb − BIAS`, computed as a 7-bit signed value.
  - `exp_ovf` if `e` ≥ 31 or either exponent field = 31; then `exp` = 5'b11111.
  - `exp_unf` if `e` ≤ 0 and not `zero`; then `exp` = 0.
  - Otherwise `exp` = `e[4:0]`.
- Zero: if either operand has exp=0 and mant=0, then `zero`=1, and `sig`, `exp`, `exp_ovf`, `exp_unf` are forced to 0. The full latency still applies, so latency is constant.
- Subnormal inputs use a hidden bit of 0 and an exponent field of 0. No pre-normalisation is done.
- DONE: `out_valid`=1 and the outputs are held stable until `out_ready`=1. On that edge the state moves to IDLE. `in_ready` stays 0 throughout MUL and DONE.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0. `sig`, `exp`, `sign`, `exp_ovf`, `exp_unf`, `zero` all reset to 0. `acc`, `cnt`, `mcand`, `mplier` are cleared.
- Accept at edge T → MUL for edges T+1..T+11 → `out_valid` is high after edge T+11, sampled first at T+12.
- Latency is 12 cycles from accept to first `out_valid`. Minimum initiation interval is 13 cycles (DONE→IDLE costs one cycle).
- Result registers are written only on the MUL→DONE transition. Holding `out_ready` low for N cycles holds every output bit-stable.
- `rst` asserted in any state returns the block to the reset values on that edge, and any in-flight operation is discarded.
- Reset dominates `in_valid` and `out_ready` on the same edge.

## Structure
- Package `fp16_pkg`:
  - `BIAS`, `MW`, `EW`=5, `SIGW`=22.
  - Enum `mul_state_t` {IDLE, MUL, DONE}.
  - Function `is_zero16`.
- One natural sub-module: `fp16_unpack` (combinational). It splits a binary16 value into sign, exp, and significand with hidden bit, and emits `is_zero` and `is_infnan`. It is instantiated twice.
- Control and datapath stay in `fp16_sig_mul`: `cnt` is 4 bits; `acc` and `mcand` are 22 bits.

## Test plan
- `a`=16'h3C00, `b`=16'h3C00 → after 12 cycles: `sig`=22'h100000, `exp`=15, `sign`=0, all flags 0.
- `a`=16'h4000, `b`=16'hC200 → `sig`=22'h180000, `exp`=17, `sign`=1.
- `a`=16'h7800, `b`=16'h7800 → `exp_ovf`=1, `exp`=31. `a`=16'h0400, `b`=16'h0400 → `exp_unf`=1, `exp`=0.
- `a`=16'h0000, `b`=16'h5555 → `zero`=1, `sig`=0, `exp`=0, `sign`=0, still at 12-cycle latency. `a`=16'h8000 → `sign`=1, `zero`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → outputs stable, `in_ready`=0, a new `in_valid` is ignored. Then `out_ready`=1 → IDLE next cycle, next operand accepted.
- Reset mid-MUL (cycle 6) → next cycle `in_ready`=1, `out_valid`=0, outputs 0. A following 16'h3C00×16'h3C00 produces the correct result.
